ram_wb_bridge: RTL and testbench
================================

Name: ram_wb_bridge

Overview:
- Sits directly upstream of the RAM controller and owns that controller's request-side inputs: requested_addr, bus_in, WEb_ram and ram_enabled, plus its bus_out read data.
- Multiplexes two masters onto the single byte-wide RAM port:
  - the CPU core, which has priority;
  - the management Wishbone slave interface, which gives the host SoC access to the 4 KiB RAM for program loading and debug.
- Each 32-bit Wishbone access is serialised into up to four byte operations, one per selected lane.
- The CPU is stalled only while a Wishbone byte operation is actually in flight.

Parameters:
- BASE_ADDR, default 32'h3000_0000: Wishbone decode base address.
- ADDR_MASK, default 32'hFFFF_0000: bits of wbs_adr_i compared against BASE_ADDR.
- RAM_BYTES, default 4096: size of the RAM window; byte offsets at or above this value are out of range.

Ports:
- wb_clk_i, input, 1: sole clock.
- rst_n, input, 1: asynchronous, active-low reset.
- wbs_cyc_i, input, 1: Wishbone cycle.
- wbs_stb_i, input, 1: Wishbone strobe.
- wbs_we_i, input, 1: Wishbone write enable.
- wbs_sel_i, input, 4: byte lane selects.
- wbs_adr_i, input, 32: byte address, word aligned.
- wbs_dat_i, input, 32: write data.
- wbs_ack_o, output, 1: single-cycle acknowledge.
- wbs_dat_o, output, 32: read data.
- cpu_req, input, 1: CPU wants the RAM port this cycle.
- cpu_addr, input, 16: CPU byte address.
- cpu_dout, input, 8: CPU write data.
- cpu_WEb, input, 1: CPU write strobe, active low.
- cpu_ram_en, input, 1: CPU RAM chip-select qualifier.
- cpu_din, output, 8: read data returned to the CPU.
- cpu_hold, output, 1: CPU must stall while this is high.
- requested_addr, output, 16: to the RAM controller.
- bus_in, output, 8: to the RAM controller.
- WEb_ram, output, 1: to the RAM controller.
- ram_enabled, output, 1: to the RAM controller.
- bus_out, input, 8: read data from the RAM controller.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE.
  - wbs_ack_o=0, wbs_dat_o=0, cpu_hold=0.
  - Latched address, select and data registers clear to 0.
  - Reset mid-operation abandons the transfer; no ack is ever issued for it.
- Decode:
  - hit = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR).
  - On a non-hit the block never acks.
- FSM states: IDLE, PEND, BYTE_A, BYTE_B, ACK.
- IDLE:
  - On hit, latch adr[15:0], sel, dat and we, and clear wbs_dat_o.
  - If offset >= RAM_BYTES, set all pending lanes to 0 (range check on the offset bits, not the full address).
  - Go to PEND.
- PEND:
  - If no pending lanes remain, go to ACK.
  - Otherwise, if cpu_req=0, go to BYTE_A on the lowest pending lane.
  - Otherwise stay in PEND; a CPU holding cpu_req starves the bridge, which is accepted behaviour.
- BYTE_A (bridge owns the port):
  - requested_addr = {adr[15:2], lane}.
  - bus_in = dat byte of that lane.
  - WEb_ram = 1.
- BYTE_B:
  - Same address and data as BYTE_A.
  - WEb_ram = ~we.
  - On a read, capture bus_out into wbs_dat_o[lane*8 +: 8] at the exiting edge.
  - Clear the lane's pending bit and return to PEND.
- ACK: wbs_ack_o=1 for exactly one cycle, then IDLE. A strobe seen in ACK is not accepted; only IDLE accepts.
- Port ownership:
  - In BYTE_A and BYTE_B: cpu_hold=1 and ram_enabled=1.
  - In all other states: requested_addr=cpu_addr, bus_in=cpu_dout, WEb_ram=cpu_WEb, ram_enabled=cpu_ram_en, and cpu_hold=0.
- cpu_din = bus_out at all times, combinational.
- Latency: with cpu_req held at 0, N selected in-range lanes, and acceptance at edge E0, ack is high in the cycle after edge E0+3N+1.
  - N=0 (sel=0 or out of range) gives ack after E0+1.
- Unselected or out-of-range read lanes return 0.
- Writes to unselected or out-of-range lanes have no RAM effect; WEb_ram is never driven low by the bridge for them.
- Simultaneous events:
  - A CPU request arriving in the same cycle the FSM leaves PEND for BYTE_A sees cpu_hold=1 in BYTE_A and must wait.
  - A BYTE_A/BYTE_B pair is never interrupted.

Test Plan:
1. Reset, then Wishbone write adr=0x3000_0010, sel=4'hF, dat=0xDDCC_BBAA, cpu_req=0 -> ack at E0+13; RAM bytes 0x10..0x13 = AA, BB, CC, DD; WEb_ram low only in the four BYTE_B cycles.
2. Read adr=0x3000_0010, sel=4'b0101 -> ack at E0+7; wbs_dat_o = 0x00CC_00AA.
3. Read adr=0x3000_1000 (out of range), sel=4'hF -> ack at E0+1; wbs_dat_o = 0; ram_enabled follows cpu_ram_en throughout.
4. Hold cpu_req=1 for 20 cycles during a pending 1-lane write -> bridge stays in PEND and cpu_hold stays 0; after release, ack arrives 4 cycles later and the CPU's own accesses pass through unchanged.
5. Assert rst_n=0 while in BYTE_A -> all outputs take reset values immediately; no ack is issued; the next transaction completes normally.
6. Non-matching address 0x3001_0000 -> no ack, bridge stays in IDLE, CPU path undisturbed.

Source files
------------

// File: rtl/ram_wb_bridge.sv
// Serialises 32-bit Wishbone accesses into byte operations on the shared RAM port; the CPU has priority.
// Ack comes 3N+1 cycles after acceptance (N live lanes); a CPU holding cpu_req parks the bridge in PEND.
module ram_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter int unsigned RAM_BYTES = 4096
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_WEb,
  input  logic        cpu_ram_en,
  output logic [7:0]  cpu_din,
  output logic        cpu_hold,
  output logic [15:0] requested_addr,
  output logic [7:0]  bus_in,
  output logic        WEb_ram,
  output logic        ram_enabled,
  input  logic [7:0]  bus_out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_BYTE_A,
    ST_BYTE_B,
    ST_ACK
  } state_t;

  localparam logic [16:0] RAM_LIMIT = 17'(RAM_BYTES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [13:0] r_adr;
  logic [3:0]  r_pend;
  logic [31:0] r_dat;
  logic        r_we;
  logic [31:0] r_rdat;

  logic        w_hit;
  logic        w_in_range;
  logic [1:0]  w_lane;
  logic [7:0]  w_wr_byte;
  logic        w_own;

  assign w_hit      = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  // Range check looks only at the offset bits, never the full bus address.
  assign w_in_range = ({1'b0, wbs_adr_i[15:0]} < RAM_LIMIT);
  assign w_wr_byte  = r_dat[{w_lane, 3'b000} +: 8];
  assign w_own      = (r_state == ST_BYTE_A) || (r_state == ST_BYTE_B);

  always_comb begin
    w_lane = 2'd0;
    if (r_pend[0])      w_lane = 2'd0;
    else if (r_pend[1]) w_lane = 2'd1;
    else if (r_pend[2]) w_lane = 2'd2;
    else if (r_pend[3]) w_lane = 2'd3;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_hit) w_state_nxt = ST_PEND;
      ST_PEND: begin
        if (r_pend == 4'b0000) w_state_nxt = ST_ACK;
        else if (!cpu_req)     w_state_nxt = ST_BYTE_A;
      end
      ST_BYTE_A: w_state_nxt = ST_BYTE_B;
      ST_BYTE_B: w_state_nxt = ST_PEND;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_adr   <= '0;
      r_pend  <= '0;
      r_dat   <= '0;
      r_we    <= 1'b0;
      r_rdat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_adr  <= wbs_adr_i[15:2];
            r_pend <= w_in_range ? wbs_sel_i : 4'b0000;
            r_dat  <= wbs_dat_i;
            r_we   <= wbs_we_i;
            r_rdat <= '0;
          end
        end
        ST_BYTE_B: begin
          r_pend[w_lane] <= 1'b0;
          if (!r_we) r_rdat[{w_lane, 3'b000} +: 8] <= bus_out;
        end
        default: ;
      endcase
    end
  end

  // Write strobe is only ever asserted in the second half of a byte pair.
  always_comb begin
    requested_addr = cpu_addr;
    bus_in         = cpu_dout;
    WEb_ram        = cpu_WEb;
    ram_enabled    = cpu_ram_en;
    cpu_hold       = 1'b0;
    if (w_own) begin
      requested_addr = {r_adr, w_lane};
      bus_in         = w_wr_byte;
      WEb_ram        = (r_state == ST_BYTE_B) ? ~r_we : 1'b1;
      ram_enabled    = 1'b1;
      cpu_hold       = 1'b1;
    end
  end

  assign wbs_ack_o = (r_state == ST_ACK);
  assign wbs_dat_o = r_rdat;
  assign cpu_din   = bus_out;

endmodule

// File: tb/tb_ram_wb_bridge.sv
// Bench for ram_wb_bridge: byte RAM behind the bridge, golden memory model, ack/data scoreboard.
module tb_ram_wb_bridge;

  logic        wb_clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_WEb = 1'b1;
  logic        cpu_ram_en = 1'b0;
  logic [7:0]  cpu_din;
  logic        cpu_hold;
  logic [15:0] requested_addr;
  logic [7:0]  bus_in;
  logic        WEb_ram;
  logic        ram_enabled;
  logic [7:0]  bus_out;

  ram_wb_bridge dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_WEb(cpu_WEb), .cpu_ram_en(cpu_ram_en), .cpu_din(cpu_din),
    .cpu_hold(cpu_hold), .requested_addr(requested_addr), .bus_in(bus_in),
    .WEb_ram(WEb_ram), .ram_enabled(ram_enabled), .bus_out(bus_out)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_cnt = 0;
  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  // RAM controller model with a backdoor used only for preloading.
  logic [7:0]  mem [0:4095];
  logic [7:0]  golden [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [7:0]  bd_dat = '0;
  always @(posedge wb_clk_i) begin
    if (bd_we) mem[bd_addr] <= bd_dat;
    else if (ram_enabled && !WEb_ram) mem[requested_addr[11:0]] <= bus_in;
  end
  assign bus_out = mem[requested_addr[11:0]];

  int n_chk = 0;
  int n_fail = 0;
  int hold_cnt = 0;
  int strobe_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endfunction

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] dat;
  } exp_t;
  exp_t q[$];

  // Ack scoreboard and per-cycle port-ownership checks.
  always @(negedge wb_clk_i) begin
    if (rst_n) begin
      chk("cpu_din", {24'h0, cpu_din}, {24'h0, bus_out});
      if (cpu_hold) begin
        hold_cnt++;
        chk("own_ram_en", {31'h0, ram_enabled}, 32'h1);
      end else begin
        chk("pass_addr", {16'h0, requested_addr}, {16'h0, cpu_addr});
        chk("pass_din", {24'h0, bus_in}, {24'h0, cpu_dout});
        chk("pass_web", {31'h0, WEb_ram}, {31'h0, cpu_WEb});
        chk("pass_en", {31'h0, ram_enabled}, {31'h0, cpu_ram_en});
      end
      if (!WEb_ram && cpu_WEb) strobe_cnt++;
      if (wbs_ack_o) begin
        chk("ack_expected", {31'h0, q.size() > 0}, 32'h1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("ack_cycle", cyc_cnt, e.cyc);
          if (e.rd) chk("rd_data", wbs_dat_o, e.dat);
        end
      end
    end
  end

  // Free-running CPU traffic; the CPU never writes unless a test drives cpu_WEb low.
  initial begin
    forever begin
      @(posedge wb_clk_i); #1;
      cpu_addr   = 16'($urandom);
      cpu_dout   = 8'($urandom);
      cpu_ram_en = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_ack();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) got = 1;
    end
    chk("ack_seen", {31'h0, got}, 32'h1);
  endtask

  // Called one step after a rising edge with the bridge idle.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    int n = 0;
    int h0, s0;
    logic [31:0] rexp = '0;
    logic [11:0] a;
    exp_t e;
    bit inr = (adr[15:0] < 16'd4096);
    for (int l = 0; l < 4; l++) begin
      a = {adr[11:2], 2'(l)};
      if (sel[l] && inr) begin
        n++;
        if (we) golden[a] = dat[l*8 +: 8];
        else rexp[l*8 +: 8] = golden[a];
      end
    end
    e.cyc = cyc_cnt + 2 + 3 * n;
    e.rd = !we;
    e.dat = rexp;
    q.push_back(e);
    h0 = hold_cnt;
    s0 = strobe_cnt;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
    wait_ack();
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    chk("hold_cycles", hold_cnt - h0, 2 * n);
    chk("web_strobes", strobe_cnt - s0, we ? n : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, edges;
    bit prev;
    exp_t e;
    logic [31:0] d;

    // Preload RAM and golden model during reset.
    for (int i = 0; i < 4096; i++) begin
      bd_we = 1; bd_addr = 12'(i); bd_dat = 8'($urandom);
      golden[i] = bd_dat;
      @(posedge wb_clk_i); #1;
      if (i == 3) begin
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_hold", {31'h0, cpu_hold}, 32'h0);
      end
    end
    bd_we = 0;
    @(negedge wb_clk_i); rst_n = 1;
    @(posedge wb_clk_i); #1;

    // Full-word write then partial read.
    wb_xfer(1, 32'h3000_0010, 4'hF, 32'hDDCC_BBAA);
    chk("mem_10", {24'h0, mem[12'h010]}, 32'hAA);
    chk("mem_11", {24'h0, mem[12'h011]}, 32'hBB);
    chk("mem_12", {24'h0, mem[12'h012]}, 32'hCC);
    chk("mem_13", {24'h0, mem[12'h013]}, 32'hDD);
    wb_xfer(0, 32'h3000_0010, 4'b0101, 32'h0);
    // Out-of-range offset and empty select.
    wb_xfer(0, 32'h3000_1000, 4'hF, 32'h0);
    wb_xfer(1, 32'h3000_1FFC, 4'hF, 32'h1234_5678);
    wb_xfer(0, 32'h3000_0020, 4'h0, 32'h0);

    // CPU starves the bridge for 20 cycles, writing memory itself.
    c = cyc_cnt;
    d = $urandom;
    cpu_req = 1;
    cpu_WEb = 1'($urandom_range(0, 1));
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
    wbs_adr_i = 32'h3000_0204; wbs_sel_i = 4'b0100; wbs_dat_i = d;
    e.cyc = c + 24; e.rd = 0; e.dat = '0;
    q.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      chk("starved_hold", {31'h0, cpu_hold}, 32'h0);
      if (cpu_ram_en && !cpu_WEb) golden[cpu_addr[11:0]] = cpu_dout;
      @(posedge wb_clk_i); #1;
      cpu_WEb = 1'($urandom_range(0, 1));
    end
    cpu_WEb = 1;
    cpu_req = 0;
    golden[12'h206] = d[23:16];
    wait_ack();
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    wb_xfer(0, 32'h3000_0204, 4'hF, 32'h0);

    // Reset in BYTE_A of the second lane of a read.
    wb_xfer(1, 32'h3000_0100, 4'hF, 32'h1122_33A5);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0;
    wbs_adr_i = 32'h3000_0100; wbs_sel_i = 4'b0011;
    edges = 0; prev = 0;
    for (int i = 0; i < 40 && edges < 2; i++) begin
      @(negedge wb_clk_i);
      if (cpu_hold && !prev) edges++;
      prev = cpu_hold;
    end
    chk("byte_a_reached", edges, 2);
    chk("pre_rst_dat", wbs_dat_o, 32'h0000_00A5);
    #1; rst_n = 0; #1;
    chk("mid_rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    chk("mid_rst_dat", wbs_dat_o, 32'h0);
    chk("mid_rst_hold", {31'h0, cpu_hold}, 32'h0);
    chk("mid_rst_addr", {16'h0, requested_addr}, {16'h0, cpu_addr});
    chk("mid_rst_en", {31'h0, ram_enabled}, {31'h0, cpu_ram_en});
    wbs_cyc_i = 0; wbs_stb_i = 0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i); rst_n = 1;
    @(posedge wb_clk_i); #1;
    wb_xfer(0, 32'h3000_0100, 4'hF, 32'h0);

    // Non-matching address and a strobe without cycle are ignored.
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
    wbs_adr_i = 32'h3001_0000; wbs_sel_i = 4'hF; wbs_dat_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      chk("miss_ack", {31'h0, wbs_ack_o}, 32'h0);
      chk("miss_hold", {31'h0, cpu_hold}, 32'h0);
      if (i == 5) begin
        wbs_cyc_i = 0;
        wbs_adr_i = 32'h3000_0000;
      end
    end
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    wb_xfer(0, 32'h3000_0000, 4'hF, 32'h0);

    // Randomized traffic, including out-of-range offsets.
    for (int i = 0; i < 40; i++) begin
      wb_xfer(1'($urandom_range(0, 1)), 32'h3000_0000 | (32'($urandom_range(0, 1100)) << 2),
              4'($urandom_range(0, 15)), $urandom);
    end
    for (int i = 0; i < 10; i++) begin
      wb_xfer(0, 32'h3000_0000 | (32'($urandom_range(0, 1023)) << 2), 4'hF, 32'h0);
    end

    repeat (3) @(posedge wb_clk_i);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
